// File: rtl/mpu_exec_seq.sv
`default_nettype none
// ============================================================================
// Module      : mpu_exec_seq
// Description : Sequential MPU execution stage; one op per handshake, with
//               host-memory loads and user interrupts as explicit wait states.
// Revision    : 1.0
// ============================================================================
module mpu_exec_seq #(
  parameter int DW         = 64,
  parameter int IPW        = 16,
  parameter int HM_TIMEOUT = 255
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [3:0]     op_op,
  input  logic [1:0]     op_size,
  input  logic [IPW-1:0] op_isize,
  input  logic [DW-1:0]  op_o0,
  input  logic [DW-1:0]  op_o1,
  input  logic [DW-1:0]  op_o2,
  input  logic [DW-1:0]  op_o3,
  input  logic [2:0]     op_s0,
  input  logic [4:0]     op_idx0,
  input  logic [DW-1:0]  alu_res,
  output logic           ip_valid,
  output logic [IPW-1:0] ip_incr,
  output logic           ip_load,
  output logic [IPW-1:0] ip_data,
  output logic           user_irq,
  output logic [DW-1:0]  user_data,
  input  logic           irq_ack,
  output logic           we,
  output logic [4:0]     w_idx,
  output logic [DW-1:0]  w_data,
  output logic [2:0]     w_r_sel,
  output logic [2:0]     w_sel,
  output logic [1:0]     w_size,
  output logic [DW-1:0]  hm_addr,
  output logic           hm_start,
  input  logic           hm_ack,
  input  logic [DW-1:0]  hm_data,
  output logic           hm_err,
  output logic           busy
);

  localparam logic [3:0] c_OP_ADD   = 4'd1;
  localparam logic [3:0] c_OP_HAMM  = 4'd2;
  localparam logic [3:0] c_OP_LOAD  = 4'd3;
  localparam logic [3:0] c_OP_MLOAD = 4'd4;
  localparam logic [3:0] c_OP_JMP   = 4'd5;
  localparam logic [3:0] c_OP_MASK  = 4'd6;
  localparam logic [3:0] c_OP_CMP   = 4'd7;
  localparam logic [3:0] c_OP_LT    = 4'd8;
  localparam logic [3:0] c_OP_INT   = 4'd9;

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_HM_REQ  = 3'd1;
  localparam logic [2:0] c_ST_HM_WAIT = 3'd2;
  localparam logic [2:0] c_ST_IRQ     = 3'd3;
  localparam logic [2:0] c_ST_RETIRE  = 3'd4;

  localparam int              c_CW   = (HM_TIMEOUT > 0) ? $clog2(HM_TIMEOUT + 1) : 1;
  localparam logic [c_CW-1:0] c_TMAX = c_CW'(HM_TIMEOUT);

  logic [2:0]     r_state, w_next, w_acc_state;
  logic           w_accept, w_timeout, w_hm_ok, w_retire;
  logic [3:0]     r_op;
  logic [1:0]     r_size;
  logic [IPW-1:0] r_isize, r_o0, r_o2, r_o3;
  logic [DW-1:0]  r_o1, r_alu;
  logic [2:0]     r_s0;
  logic [4:0]     r_idx0;
  logic [c_CW-1:0] r_cnt;

  // Retire fields come straight from the inputs when an op retires on the
  // edge that accepts it, otherwise from the latched copy.
  logic [3:0]     w_s_op;
  logic [1:0]     w_s_size;
  logic [IPW-1:0] w_s_isize, w_s_o0, w_s_o2, w_s_o3;
  logic [DW-1:0]  w_s_o1, w_s_alu;
  logic [2:0]     w_s_s0;
  logic [4:0]     w_s_idx0;

  logic           r_ip_valid, r_ip_load, r_user_irq, r_we, r_hm_start, r_hm_err, r_busy;
  logic [IPW-1:0] r_ip_incr, r_ip_data;
  logic [DW-1:0]  r_user_data, r_w_data, r_hm_addr;
  logic [4:0]     r_w_idx;
  logic [2:0]     r_w_r_sel;
  logic [1:0]     r_w_size;

  logic           w_ip_load_d, w_we_d;
  logic [IPW-1:0] w_ip_data_d;
  logic [DW-1:0]  w_w_data_d;

  logic w_unused;
  assign w_unused = ^{op_o2[DW-1:IPW], op_o3[DW-1:IPW]};

  assign op_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_RETIRE);
  assign w_accept  = op_valid && op_ready;
  assign w_timeout = (HM_TIMEOUT != 0) && (r_cnt == c_TMAX);
  assign w_hm_ok   = (r_state == c_ST_HM_WAIT) && hm_ack;

  assign w_s_op    = w_accept ? op_op             : r_op;
  assign w_s_size  = w_accept ? op_size           : r_size;
  assign w_s_isize = w_accept ? op_isize          : r_isize;
  assign w_s_o0    = w_accept ? op_o0[IPW-1:0]    : r_o0;
  assign w_s_o1    = w_accept ? op_o1             : r_o1;
  assign w_s_o2    = w_accept ? op_o2[IPW-1:0]    : r_o2;
  assign w_s_o3    = w_accept ? op_o3[IPW-1:0]    : r_o3;
  assign w_s_alu   = w_accept ? alu_res           : r_alu;
  assign w_s_s0    = w_accept ? op_s0             : r_s0;
  assign w_s_idx0  = w_accept ? op_idx0           : r_idx0;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= c_ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_acc_state = c_ST_RETIRE;
    if (op_op == c_OP_MLOAD)    w_acc_state = c_ST_HM_REQ;
    else if (op_op == c_OP_INT) w_acc_state = c_ST_IRQ;
    w_next = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_RETIRE: w_next = w_accept ? w_acc_state : c_ST_IDLE;
      c_ST_HM_REQ:            w_next = c_ST_HM_WAIT;
      c_ST_HM_WAIT:           if (hm_ack || w_timeout) w_next = c_ST_RETIRE;
      c_ST_IRQ:               if (irq_ack) w_next = c_ST_RETIRE;
      default:                w_next = c_ST_IDLE;
    endcase
  end

  // Output decode: next values for the registered retire outputs
  always_comb begin
    w_retire    = (w_next == c_ST_RETIRE);
    w_ip_load_d = 1'b0;
    w_ip_data_d = '0;
    case (w_s_op)
      c_OP_JMP:            begin w_ip_load_d = 1'b1;        w_ip_data_d = w_s_o0; end
      c_OP_MASK, c_OP_CMP: begin w_ip_load_d = ~w_s_alu[0]; w_ip_data_d = w_s_o3; end
      c_OP_LT:             begin w_ip_load_d = ~w_s_alu[0]; w_ip_data_d = w_s_o2; end
      default:             ;
    endcase
    w_we_d     = 1'b0;
    w_w_data_d = r_w_data;
    case (w_s_op)
      c_OP_ADD, c_OP_HAMM: begin w_we_d = 1'b1; w_w_data_d = w_s_alu; end
      c_OP_LOAD:           begin w_we_d = 1'b1; w_w_data_d = w_s_o1;  end
      c_OP_MLOAD:          if (w_hm_ok) begin w_we_d = 1'b1; w_w_data_d = hm_data; end
      default:             ;
    endcase
  end

  // Operand latch and host-memory timeout counter
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_op <= '0; r_size <= '0; r_isize <= '0; r_o0 <= '0; r_o1 <= '0;
      r_o2 <= '0; r_o3 <= '0; r_alu <= '0; r_s0 <= '0; r_idx0 <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_op <= op_op; r_size <= op_size; r_isize <= op_isize;
        r_o0 <= op_o0[IPW-1:0]; r_o1 <= op_o1;
        r_o2 <= op_o2[IPW-1:0]; r_o3 <= op_o3[IPW-1:0];
        r_alu <= alu_res; r_s0 <= op_s0; r_idx0 <= op_idx0;
        r_cnt <= '0;
      end else if (((r_state == c_ST_HM_REQ) || (r_state == c_ST_HM_WAIT)) &&
                   (r_cnt != c_TMAX)) begin
        r_cnt <= r_cnt + c_CW'(1);
      end
    end
  end

  // Output registers
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_ip_valid <= 1'b0; r_ip_load <= 1'b0; r_user_irq <= 1'b0; r_we <= 1'b0;
      r_hm_start <= 1'b0; r_hm_err <= 1'b0; r_busy <= 1'b0;
      r_ip_incr <= '0; r_ip_data <= '0; r_user_data <= '0; r_w_data <= '0;
      r_hm_addr <= '0; r_w_idx <= '0; r_w_r_sel <= '0; r_w_size <= '0;
    end else begin
      r_ip_valid <= w_retire;
      r_ip_load  <= w_retire && w_ip_load_d;
      r_we       <= w_retire && w_we_d;
      r_hm_start <= (w_next == c_ST_HM_REQ);
      r_hm_err   <= (r_state == c_ST_HM_WAIT) && !hm_ack && w_timeout;
      r_user_irq <= (w_next == c_ST_IRQ);
      r_busy     <= (w_next != c_ST_IDLE);
      if (w_retire) begin
        r_ip_incr <= w_s_isize;
        r_ip_data <= w_ip_data_d;
        r_w_data  <= w_w_data_d;
        r_w_idx   <= w_s_idx0;
        r_w_r_sel <= w_s_s0;
        r_w_size  <= w_s_size;
      end
      if (w_accept && (op_op == c_OP_MLOAD)) r_hm_addr   <= op_o1;
      if (w_accept && (op_op == c_OP_INT))   r_user_data <= op_o0;
    end
  end

  assign ip_valid  = r_ip_valid;
  assign ip_incr   = r_ip_incr;
  assign ip_load   = r_ip_load;
  assign ip_data   = r_ip_data;
  assign user_irq  = r_user_irq;
  assign user_data = r_user_data;
  assign we        = r_we;
  assign w_idx     = r_w_idx;
  assign w_data    = r_w_data;
  assign w_r_sel   = r_w_r_sel;
  assign w_sel     = 3'd0;
  assign w_size    = r_w_size;
  assign hm_addr   = r_hm_addr;
  assign hm_start  = r_hm_start;
  assign hm_err    = r_hm_err;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/mpu_exec_seq.md
# mpu_exec_seq

Sequential, parametrised execution stage for the MPU. It accepts one decoded instruction per valid/ready handshake and evaluates jumps against the ALU result. It runs host-memory loads and user interrupts as explicit waiting states rather than relying on external stall logic, and retires each instruction with a single-cycle registered writeback and IP-update pulse. It sits between the decoder/operand fetch (with its external `mpu_alu`) and the register file / IP unit.

## Interface
- `DW`, 64: operand, result and host-memory data width.
- `IPW`, 16: instruction-pointer width.
- `HM_TIMEOUT`, 255: maximum `HM_WAIT` cycles before an abort; 0 disables the timeout.
- `sys_clk  in  1`: clock; all state changes on the rising edge.
- `sys_rst  in  1`: asynchronous, active-low reset.
- `op_valid  in  1` / `op_ready  out  1`: instruction handshake; accept when both are high.
- `op_op  in  4`: opcode (`MPU_OP_*` from `mpu.vh`). `op_size  in  2`. `op_isize  in  IPW`: instruction size in bytes.
- `op_o0..op_o3  in  DW`: operands. `op_s0  in  3`: destination register select. `op_idx0  in  5`: destination index.
- `alu_res  in  DW`: combinational result from the external ALU for the current `op_*`.
- `ip_valid  out  1`: retire pulse. `ip_incr  out  IPW`. `ip_load  out  1`. `ip_data  out  IPW`.
- `user_irq  out  1`: interrupt request. `user_data  out  DW`. `irq_ack  in  1`.
- `we  out  1`, `w_idx  out  5`, `w_data  out  DW`, `w_r_sel  out  3`, `w_sel  out  3` (constant 0), `w_size  out  2`: register-file write port.
- `hm_addr  out  DW`, `hm_start  out  1`, `hm_ack  in  1`, `hm_data  in  DW`: host-memory read port.
- `hm_err  out  1`: one-cycle pulse when a host-memory load times out.
- `busy  out  1`: high in any state other than `IDLE`.

## Operation
- **States:** `IDLE`, `HM_REQ`, `HM_WAIT`, `IRQ`, `RETIRE`.
- **Ready:** `op_ready` = (state is `IDLE` or `RETIRE`).
- **On accept:** latch opcode, operands, size, isize, s0, idx0 and `alu_res`. Next state:
  - `MLOAD` → `HM_REQ`
  - `INT` → `IRQ`
  - all other opcodes → `RETIRE`
- **HM_REQ** (one cycle): `hm_start`=1, `hm_addr`=latched o1; clear the timeout counter; go to `HM_WAIT`.
- **HM_WAIT:**
  - `hm_ack`=1: capture `hm_data` into `w_data`, go to `RETIRE`.
  - Otherwise, if `HM_TIMEOUT`≠0 and the counter equals `HM_TIMEOUT`: pulse `hm_err`, go to `RETIRE` with write suppressed.
  - `hm_ack` and timeout in the same cycle: `hm_ack` wins.
- **IRQ:** `user_irq`=1, `user_data`=latched o0. Stay until `irq_ack`=1, then go to `RETIRE`.
- **RETIRE** (one cycle):
  - `ip_valid`=1, `ip_incr`=latched isize.
  - `we`=1 for `ADD`, `HAMM`, `LOAD`, and for `MLOAD` that did not time out.
  - `w_data`:
    - `ADD`/`HAMM`: latched `alu_res`
    - `LOAD`: latched o1
    - `MLOAD`: captured `hm_data`
  - `w_idx`=idx0, `w_r_sel`=s0, `w_size`=size.
  - If a new op is accepted in `RETIRE`, transition per the accept rule; otherwise go to `IDLE`.
- **Jumps** (evaluated in `RETIRE`; "false" means latched `alu_res[0]`==0):
  - `JMP`: `ip_load`=1, `ip_data`=o0[IPW-1:0].
  - `MASK`/`CMP`: `ip_load`=false, `ip_data`=o3[IPW-1:0].
  - `LT`: `ip_load`=false, `ip_data`=o2[IPW-1:0].
  - Otherwise `ip_data`=0.
- **Pulse outputs** (`we`, `ip_valid`, `ip_load`, `hm_start`, `hm_err`) are high for exactly one cycle. Data outputs hold their values until the next retire.
- **Ignored inputs:** `hm_ack` outside `HM_WAIT`, and `irq_ack` outside `IRQ`.
- **Timeout counter:** width `$clog2(HM_TIMEOUT+1)`; it saturates and never wraps.

## Timing
- **Reset:** asserting `sys_rst` low forces `IDLE` immediately and clears every output and latch to 0, including mid-load and mid-IRQ. A late `hm_ack` after release is ignored.
- **Output registers:** all outputs are registered except `op_ready`, which is decoded from state.
- **Latency, ALU/jump op:** accepted at edge N, retire outputs valid in cycle N+1. Throughput is one op per cycle with back-to-back `op_valid`.
- **Latency, MLOAD:**
  - Accepted at N; `hm_start` in N+1.
  - `hm_ack` in cycle N+1+k (k≥1) gives retire in N+2+k.
  - Timeout gives retire in N+2+`HM_TIMEOUT`.
- **Latency, INT:** `user_irq` rises in N+1. An `irq_ack` sampled in cycle M gives retire in M+1, with `user_irq` low from M+1.

## Test plan
- **Reset:** hold `sys_rst`=0 → all outputs 0, `op_ready`=1, `busy`=0.
- **Back-to-back ADD:** two ADDs with `alu_res`=5 then 9, idx0=3 then 4, isize=4 → `we`/`ip_valid` high two consecutive cycles, w_data 5 then 9, `ip_incr`=4, `ip_load`=0.
- **CMP jump:** CMP, `alu_res`=0, o3=0x0120 → `ip_load`=1, `ip_data`=0x0120. Same op with `alu_res`=1 → `ip_load`=0.
- **MLOAD ack:** MLOAD o1=0x1000, ack after 3 cycles with `hm_data`=0xDEAD → `hm_start` single pulse with `hm_addr`=0x1000, retire `we`=1, `w_data`=0xDEAD, total 5 cycles.
- **MLOAD timeout:** `HM_TIMEOUT`=4, no ack → `hm_err` pulse, retire with `we`=0. Separately, ack in the timeout cycle → `we`=1, no `hm_err`.
- **INT and reset abort:** INT o0=0x42 → `user_irq`=1, `user_data`=0x42 until `irq_ack`, then retire. Reset asserted mid-`HM_WAIT` → `IDLE`, later `hm_ack` causes no `we`.
